xpb_seq_accum: RTL and testbench

- Sequential reduction stage that consumes the outputs of the per-segment xpb lookup tables.
- It takes the upper product bits in SEG_W-bit segments, one segment per cycle. For each segment it drives a segment select and a table index to the external xpb table bank, then registers the returned WORD_W-bit value.
- The returned values are summed onto the low product word.
- The result is a partially reduced accumulator word that feeds the next modular-square reduction stage.

---
 rtl/xpb_seq_accum_if.sv | 31 +++
 rtl/xpb_seq_accum.sv | 88 ++++++++
 tb/tb_xpb_seq_accum.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xpb_seq_accum_if.sv
// Operand, xpb table bank and result signals of the sequential xpb accumulator.
// master = operand/table/result side, slave = accumulator core.
interface xpb_seq_accum_if #(
   parameter int WORD_W   = 1024,
   parameter int SEG_W    = 5,
   parameter int NUM_SEGS = 8
);
   localparam int SEL_W = $clog2(NUM_SEGS);
   localparam int ACC_W = WORD_W + $clog2(NUM_SEGS + 1);

   logic                      in_valid;
   logic                      in_ready;
   logic [WORD_W-1:0]         in_low;
   logic [SEG_W*NUM_SEGS-1:0] in_high;
   logic [SEL_W-1:0]          lut_seg;
   logic [SEG_W-1:0]          lut_idx;
   logic [WORD_W-1:0]         lut_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [ACC_W-1:0]          out_sum;

   modport master (
      output in_valid, in_low, in_high, lut_data, out_ready,
      input  in_ready, lut_seg, lut_idx, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_low, in_high, lut_data, out_ready,
      output in_ready, lut_seg, lut_idx, out_valid, out_sum
   );
endinterface

// File: rtl/xpb_seq_accum.sv
// Sequential xpb reduction: one upper-product segment looked up per cycle,
// registered table values summed onto the low product word.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// LOOKUP | one segment issued per cycle, previous lookup added
// DRAIN  | last registered lookup added
// DONE   | result presented until out_ready
module xpb_seq_accum #(
   parameter int WORD_W   = 1024,
   parameter int SEG_W    = 5,
   parameter int NUM_SEGS = 8
) (
   input logic           clk,
   input logic           rst_n,
   xpb_seq_accum_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_SEGS);
   localparam int ACC_W = WORD_W + $clog2(NUM_SEGS + 1);
   localparam int HI_W  = SEG_W * NUM_SEGS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [SEL_W-1:0] LAST_SEG = SEL_W'(NUM_SEGS - 1);

   logic [1:0]        state;
   logic [ACC_W-1:0]  acc;
   logic [HI_W-1:0]   shreg;
   logic [WORD_W-1:0] lut_q;
   logic              q_valid;
   logic [SEL_W-1:0]  counter;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   // Result only visible in DONE so a partial sum never leaks out.
   assign bus.out_sum   = (state == DONE) ? acc : '0;
   assign bus.lut_seg   = (state == LOOKUP) ? counter : '0;
   assign bus.lut_idx   = (state == LOOKUP) ? shreg[SEG_W-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         shreg   <= '0;
         lut_q   <= '0;
         q_valid <= 1'b0;
         counter <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc     <= ACC_W'(bus.in_low);
                  shreg   <= bus.in_high;
                  counter <= '0;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               // Table output is registered first to keep the wide adder off the LUT path.
               lut_q   <= bus.lut_data;
               q_valid <= 1'b1;
               shreg   <= shreg >> SEG_W;
               counter <= counter + SEL_W'(1);
               if (q_valid) begin
                  acc <= acc + ACC_W'(lut_q);
               end
               if (counter == LAST_SEG) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               acc     <= acc + ACC_W'(lut_q);
               q_valid <= 1'b0;
               state   <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xpb_seq_accum.sv
// Directed and randomized checks of xpb_seq_accum against a sum-of-table-values model.
module tb_xpb_seq_accum;
   localparam int WORD_W   = 1024;
   localparam int SEG_W    = 5;
   localparam int NUM_SEGS = 8;
   localparam int ACC_W    = WORD_W + $clog2(NUM_SEGS + 1);
   localparam int HI_W     = SEG_W * NUM_SEGS;

   logic clk;
   logic rst_n;
   int   lut_mode;
   int   n_cmp;
   int   n_fail;

   xpb_seq_accum_if #(.WORD_W(WORD_W), .SEG_W(SEG_W), .NUM_SEGS(NUM_SEGS)) bus ();

   xpb_seq_accum #(.WORD_W(WORD_W), .SEG_W(SEG_W), .NUM_SEGS(NUM_SEGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode 0: 1000*seg+idx, mode 1: all ones, mode 2: zero
   function automatic logic [WORD_W-1:0] lut_val(input int mode, input int seg, input int idx);
      logic [WORD_W-1:0] v;
      if (mode == 1)      v = '1;
      else if (mode == 2) v = '0;
      else                v = WORD_W'(1000 * seg + idx);
      return v;
   endfunction

   assign bus.lut_data = lut_val(lut_mode, int'(bus.lut_seg), int'(bus.lut_idx));

   function automatic logic [ACC_W-1:0] ref_sum(input int mode, input logic [WORD_W-1:0] low,
                                                 input logic [HI_W-1:0] high);
      logic [ACC_W-1:0] s;
      s = ACC_W'(low);
      for (int i = 0; i < NUM_SEGS; i++)
         s = s + ACC_W'(lut_val(mode, i, int'(high[i*SEG_W +: SEG_W])));
      return s;
   endfunction

   function automatic logic [WORD_W-1:0] rand_word();
      logic [WORD_W-1:0] w;
      for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, ACC_W'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, ACC_W'(bus.out_valid), 0);
      chk({tag, "_out_sum"}, bus.out_sum, 0);
      chk({tag, "_lut_seg"}, ACC_W'(bus.lut_seg), 0);
      chk({tag, "_lut_idx"}, ACC_W'(bus.lut_idx), 0);
   endtask

   // Offer an operand, follow the lookup sequence, stop with the result in DONE.
   task automatic run_to_done(input string tag, input logic [WORD_W-1:0] low,
                              input logic [HI_W-1:0] high, input logic [ACC_W-1:0] exp);
      int budget;
      budget = 0;
      while (!bus.in_ready && budget < 20) begin
         step();
         budget++;
      end
      chk({tag, "_ready_before_accept"}, ACC_W'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_low   = low;
      bus.in_high  = high;
      step();
      bus.in_valid = 1'b0;
      for (int k = 0; k < NUM_SEGS; k++) begin
         chk({tag, "_lut_seg"}, ACC_W'(bus.lut_seg), ACC_W'(k));
         chk({tag, "_lut_idx"}, ACC_W'(bus.lut_idx), ACC_W'(high[k*SEG_W +: SEG_W]));
         chk({tag, "_busy_ready"}, ACC_W'(bus.in_ready), 0);
         chk({tag, "_early_valid"}, ACC_W'(bus.out_valid), 0);
         step();
      end
      chk({tag, "_drain_valid"}, ACC_W'(bus.out_valid), 0);
      chk({tag, "_drain_lut_seg"}, ACC_W'(bus.lut_seg), 0);
      step();
      chk({tag, "_out_valid"}, ACC_W'(bus.out_valid), 1);
      chk({tag, "_out_sum"}, bus.out_sum, exp);
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_valid_fall"}, ACC_W'(bus.out_valid), 0);
      chk({tag, "_ready_back"}, ACC_W'(bus.in_ready), 1);
   endtask

   initial begin
      logic [WORD_W-1:0] low, low_b;
      logic [HI_W-1:0]   high, high_b;
      logic [ACC_W-1:0]  exp, exp_b, held;
      int acc_cyc[2];
      int nacc, nres;
      bit prev_v, acc_now;

      n_cmp = 0;
      n_fail = 0;
      lut_mode = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_low    = '0;
      bus.in_high   = '0;
      bus.out_ready = 1'b0;
      #1;
      chk_reset_outputs("reset");
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_reset_outputs("post_reset");

      // Zero operand
      lut_mode = 0;
      run_to_done("zero", WORD_W'(5), '0, ACC_W'(28005));
      release_result("zero");

      // All-ones segments
      run_to_done("ones", '0, '1, ACC_W'(28248));
      release_result("ones");

      // Random operands
      for (int r = 0; r < 4; r++) begin
         low  = rand_word();
         high = {$urandom, $urandom};
         run_to_done("rand", low, high, ref_sum(0, low, high));
         release_result("rand");
      end

      // Worst case: every table value and the seed at their maximum
      lut_mode = 1;
      high = {$urandom, $urandom};
      exp  = ref_sum(1, '1, high);
      run_to_done("worst", '1, high, exp);
      chk("worst_top_bits", ACC_W'(bus.out_sum[ACC_W-1:WORD_W]), ACC_W'(4'b1000));
      chk("worst_low_word", ACC_W'(bus.out_sum[WORD_W-1:0]), ACC_W'({WORD_W{1'b1}} - WORD_W'(8)));
      release_result("worst");

      // Backpressure in DONE with in_valid pulses
      lut_mode = 0;
      low  = rand_word();
      high = {$urandom, $urandom};
      exp  = ref_sum(0, low, high);
      run_to_done("bp", low, high, exp);
      held = bus.out_sum;
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = c[0];
         bus.in_low   = rand_word();
         bus.in_high  = '1;
         step();
         chk("bp_valid_hold", ACC_W'(bus.out_valid), 1);
         chk("bp_sum_hold", bus.out_sum, held);
         chk("bp_in_ready", ACC_W'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      release_result("bp");
      step();
      chk("bp_no_capture", ACC_W'(bus.in_ready), 1);

      // Reset mid-LOOKUP after four segments issued
      bus.in_valid = 1'b1;
      bus.in_low   = rand_word();
      bus.in_high  = '1;
      step();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("abort_busy", ACC_W'(bus.in_ready), 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      #2;
      rst_n = 1'b1;
      step();
      lut_mode = 2;
      run_to_done("after_abort", WORD_W'(7), '0, ACC_W'(7));
      release_result("after_abort");

      // Back-to-back with out_ready tied high
      lut_mode = 0;
      low    = rand_word();
      high   = {$urandom, $urandom};
      low_b  = rand_word();
      high_b = {$urandom, $urandom};
      exp    = ref_sum(0, low, high);
      exp_b  = ref_sum(0, low_b, high_b);
      nacc = 0;
      nres = 0;
      prev_v = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_low    = low;
      bus.in_high   = high;
      for (int c = 0; c < 40; c++) begin
         if (prev_v) chk("b2b_pulse_len", ACC_W'(bus.out_valid), 0);
         prev_v = bus.out_valid;
         if (bus.out_valid) begin
            chk("b2b_sum", bus.out_sum, (nres == 0) ? exp : exp_b);
            nres++;
         end
         acc_now = bus.in_ready && bus.in_valid;
         if (acc_now) acc_cyc[nacc] = c;
         step();
         if (acc_now) begin
            nacc++;
            if (nacc == 1) begin
               bus.in_low  = low_b;
               bus.in_high = high_b;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (nres == 2 && !prev_v) break;
      end
      chk("b2b_accepts", ACC_W'(nacc), 2);
      chk("b2b_results", ACC_W'(nres), 2);
      if (nacc == 2) chk("b2b_spacing", ACC_W'(acc_cyc[1] - acc_cyc[0]), ACC_W'(NUM_SEGS + 3));
      bus.out_ready = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
